// File: rtl/mux21_arbiter.sv
// rtl/mux21_arbiter.sv - sticky round-robin arbiter driving a registered 2:1 output channel
module mux21_arbiter #(
  parameter int WIDTH     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic [WIDTH-1:0] a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic [WIDTH-1:0] f,
  output logic             f_valid,
  input  logic             f_ready,
  output logic             sel
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);
  localparam logic [CW-1:0] ONE_CNT = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;      // 1 means B was the most recent owner
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    cnt_inc;
  logic [WIDTH-1:0] f_q;
  logic             f_valid_q;
  logic             sel_q;
  logic             accept;

  assign accept  = !f_valid_q || f_ready;
  assign cnt_inc = (cnt_q < MAX_CNT) ? cnt_q + ONE_CNT : cnt_q;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt_a   = 1'b0;
    gnt_b   = 1'b0;
    // Grants are suppressed in reset so nothing is accepted into a discarded slot
    if (rst_n && accept) begin
      unique case (state_q)
        IDLE: begin
          if (req_a && (!req_b || last_q)) begin
            gnt_a   = 1'b1;
            state_d = OWN_A;
            cnt_d   = ONE_CNT;
          end else if (req_b) begin
            gnt_b   = 1'b1;
            state_d = OWN_B;
            cnt_d   = ONE_CNT;
          end
        end
        OWN_A: begin
          if (req_a && (cnt_q < MAX_CNT || !req_b)) begin
            gnt_a = 1'b1;
            cnt_d = cnt_inc;
          end else if (req_b) begin
            gnt_b   = 1'b1;
            state_d = OWN_B;
            cnt_d   = ONE_CNT;
            last_d  = 1'b0;
          end else begin
            state_d = IDLE;
            last_d  = 1'b0;
          end
        end
        OWN_B: begin
          if (req_b && (cnt_q < MAX_CNT || !req_a)) begin
            gnt_b = 1'b1;
            cnt_d = cnt_inc;
          end else if (req_a) begin
            gnt_a   = 1'b1;
            state_d = OWN_A;
            cnt_d   = ONE_CNT;
            last_d  = 1'b1;
          end else begin
            state_d = IDLE;
            last_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      f_q       <= '0;
      f_valid_q <= 1'b0;
      sel_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        if (req_a && gnt_a) begin
          f_q       <= a;
          sel_q     <= 1'b0;
          f_valid_q <= 1'b1;
        end else if (req_b && gnt_b) begin
          f_q       <= b;
          sel_q     <= 1'b1;
          f_valid_q <= 1'b1;
        end else if (f_ready) begin
          f_valid_q <= 1'b0;
        end
      end
    end
  end

  assign f       = f_q;
  assign f_valid = f_valid_q;
  assign sel     = sel_q;

endmodule

// File: tb/tb_mux21_arbiter.sv
// tb/tb_mux21_arbiter.sv - directed and randomized checks of mux21_arbiter
module tb_mux21_arbiter;
  localparam int WIDTH     = 4;
  localparam int MAX_BURST = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_a = 1'b0;
  logic             req_b = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             f_ready = 1'b1;
  logic             gnt_a, gnt_b, f_valid, sel;
  logic [WIDTH-1:0] f;

  int n_checks = 0;
  int n_pass   = 0;

  mux21_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .a(a), .req_b(req_b), .b(b),
    .gnt_a(gnt_a), .gnt_b(gnt_b),
    .f(f), .f_valid(f_valid), .f_ready(f_ready), .sel(sel)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; f_ready = 1'b1; a = '0; b = '0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_a = 1'b1; req_b = 1'b1; a = 4'h3; b = 4'h9; f_ready = 1'b1;
    tick(); tick();
    n_checks++;
    if ({gnt_a, gnt_b} !== 2'b00) $display("FAIL reset_gnt: got %b expected 00", {gnt_a, gnt_b});
    else n_pass++;
    n_checks++;
    if ({f_valid, sel, f} !== 6'b0) $display("FAIL reset_out: got %b expected 000000", {f_valid, sel, f});
    else n_pass++;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({gnt_a, gnt_b} !== 2'b10) $display("FAIL reset_release_gnt: got %b expected 10", {gnt_a, gnt_b});
    else n_pass++;
    tick();
    n_checks++;
    if ({f_valid, sel, f} !== {1'b1, 1'b0, 4'h3}) $display("FAIL reset_first_word: got %b expected %b", {f_valid, sel, f}, {1'b1, 1'b0, 4'h3});
    else n_pass++;
  endtask

  task automatic test_single();
    logic [WIDTH-1:0] vals [8];
    vals = '{4'b0101, 4'b1100, 4'h7, 4'h0, 4'hF, 4'h2, 4'hA, 4'h4};
    apply_reset();
    req_b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b = vals[i];
      #1;
      n_checks++;
      if ({gnt_a, gnt_b} !== 2'b01) $display("FAIL single_gnt[%0d]: got %b expected 01", i, {gnt_a, gnt_b});
      else n_pass++;
      tick();
      n_checks++;
      if ({f_valid, sel, f} !== {1'b1, 1'b1, vals[i]}) $display("FAIL single_out[%0d]: got %b expected %b", i, {f_valid, sel, f}, {1'b1, 1'b1, vals[i]});
      else n_pass++;
    end
    req_b = 1'b0;
  endtask

  task automatic test_contention();
    logic             exp_b;
    logic [WIDTH-1:0] word;
    apply_reset();
    req_a = 1'b1; req_b = 1'b1; a = 4'h1; b = 4'h8;
    for (int i = 0; i < 12; i++) begin
      exp_b = ((i / MAX_BURST) % 2) == 1;
      word  = exp_b ? b : a;
      #1;
      n_checks++;
      if ({gnt_a, gnt_b} !== {!exp_b, exp_b}) $display("FAIL contention_gnt[%0d]: got %b expected %b", i, {gnt_a, gnt_b}, {!exp_b, exp_b});
      else n_pass++;
      tick();
      n_checks++;
      if ({f_valid, sel, f} !== {1'b1, exp_b, word}) $display("FAIL contention_out[%0d]: got %b expected %b", i, {f_valid, sel, f}, {1'b1, exp_b, word});
      else n_pass++;
      if (exp_b) b = b + 4'h1;
      else a = a + 4'h1;
    end
    req_a = 1'b0; req_b = 1'b0;
  endtask

  task automatic test_backpressure();
    logic             own_b [4];
    logic [WIDTH-1:0] words [4];
    own_b = '{1'b0, 1'b0, 1'b1, 1'b1};
    words = '{4'h3, 4'h4, 4'h8, 4'h9};
    apply_reset();
    req_a = 1'b1; req_b = 1'b1; a = 4'h1; b = 4'h8;
    tick(); a = 4'h2;
    tick(); a = 4'h3;
    f_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if ({gnt_a, gnt_b} !== 2'b00) $display("FAIL bp_gnt[%0d]: got %b expected 00", k, {gnt_a, gnt_b});
      else n_pass++;
      tick();
      n_checks++;
      if ({f_valid, sel, f} !== {1'b1, 1'b0, 4'h2}) $display("FAIL bp_hold[%0d]: got %b expected %b", k, {f_valid, sel, f}, {1'b1, 1'b0, 4'h2});
      else n_pass++;
    end
    f_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      n_checks++;
      if ({gnt_a, gnt_b} !== {!own_b[j], own_b[j]}) $display("FAIL bp_resume_gnt[%0d]: got %b expected %b", j, {gnt_a, gnt_b}, {!own_b[j], own_b[j]});
      else n_pass++;
      tick();
      n_checks++;
      if ({f_valid, sel, f} !== {1'b1, own_b[j], words[j]}) $display("FAIL bp_resume_out[%0d]: got %b expected %b", j, {f_valid, sel, f}, {1'b1, own_b[j], words[j]});
      else n_pass++;
      if (own_b[j]) b = b + 4'h1;
      else a = a + 4'h1;
    end
    req_a = 1'b0; req_b = 1'b0;
  endtask

  task automatic test_release_tiebreak();
    apply_reset();
    req_a = 1'b1; req_b = 1'b0; a = 4'h6; b = 4'hA;
    tick();
    req_a = 1'b0; f_ready = 1'b0;
    tick();
    n_checks++;
    if ({f_valid, f} !== {1'b1, 4'h6}) $display("FAIL release_hold: got %b expected %b", {f_valid, f}, {1'b1, 4'h6});
    else n_pass++;
    f_ready = 1'b1;
    #1;
    n_checks++;
    if ({gnt_a, gnt_b} !== 2'b00) $display("FAIL release_nogrant: got %b expected 00", {gnt_a, gnt_b});
    else n_pass++;
    tick();
    n_checks++;
    if (f_valid !== 1'b0) $display("FAIL release_drain: got %b expected 0", f_valid);
    else n_pass++;
    req_a = 1'b1; req_b = 1'b1;
    #1;
    n_checks++;
    if ({gnt_a, gnt_b} !== 2'b01) $display("FAIL tiebreak_gnt: got %b expected 01", {gnt_a, gnt_b});
    else n_pass++;
    tick();
    n_checks++;
    if ({f_valid, sel, f} !== {1'b1, 1'b1, 4'hA}) $display("FAIL tiebreak_out: got %b expected %b", {f_valid, sel, f}, {1'b1, 1'b1, 4'hA});
    else n_pass++;
    req_a = 1'b0; req_b = 1'b0;
  endtask

  task automatic test_reset_midburst();
    apply_reset();
    req_a = 1'b1; req_b = 1'b1; a = 4'h1; b = 4'h8;
    tick(); a = 4'h2;
    tick(); a = 4'h3;
    #1;
    n_checks++;
    if ({gnt_a, gnt_b} !== 2'b10) $display("FAIL midburst_third: got %b expected 10", {gnt_a, gnt_b});
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({gnt_a, gnt_b} !== 2'b00) $display("FAIL midburst_rst_gnt: got %b expected 00", {gnt_a, gnt_b});
    else n_pass++;
    tick();
    n_checks++;
    if ({f_valid, sel, f} !== 6'b0) $display("FAIL midburst_rst_out: got %b expected 000000", {f_valid, sel, f});
    else n_pass++;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({gnt_a, gnt_b} !== 2'b10) $display("FAIL midburst_restart: got %b expected 10", {gnt_a, gnt_b});
    else n_pass++;
    tick();
    req_a = 1'b0; req_b = 1'b0;
  endtask

  // Arbitration rule as stated: owner 0 = none, 1 = A, 2 = B
  function automatic int pick(int owner, int run, int last, bit ra, bit rb);
    bit mine, other;
    if (owner == 0) begin
      if (ra && rb) return (last == 2) ? 1 : 2;
      if (ra) return 1;
      if (rb) return 2;
      return 0;
    end
    mine  = (owner == 1) ? ra : rb;
    other = (owner == 1) ? rb : ra;
    if (mine && (run < MAX_BURST || !other)) return owner;
    if (other) return 3 - owner;
    return 0;
  endfunction

  task automatic test_random();
    logic [WIDTH:0] q [$];
    int  owner, run, last, g;
    bit  acc, consumed;
    apply_reset();
    owner = 0; run = 0; last = 2;
    for (int i = 0; i < 600; i++) begin
      f_ready = ($urandom % 4) != 0;
      #1;
      acc = (q.size() == 0) || f_ready;
      g   = acc ? pick(owner, run, last, req_a, req_b) : 0;
      n_checks++;
      if ({gnt_a, gnt_b} !== {g == 1, g == 2}) $display("FAIL rand_gnt[%0d]: got %b expected %b", i, {gnt_a, gnt_b}, {g == 1, g == 2});
      else n_pass++;
      consumed = (q.size() != 0) && f_ready;
      tick();
      if (consumed) q.delete(0);
      if (g == 1) q.push_back({1'b0, a});
      if (g == 2) q.push_back({1'b1, b});
      if (acc) begin
        if (g == 0) begin
          if (owner != 0) last = owner;
          owner = 0;
        end else if (g == owner) begin
          run = (run < MAX_BURST) ? run + 1 : MAX_BURST;
        end else begin
          if (owner != 0) last = owner;
          owner = g;
          run = 1;
        end
      end
      n_checks++;
      if (f_valid !== (q.size() != 0)) $display("FAIL rand_valid[%0d]: got %b expected %b", i, f_valid, q.size() != 0);
      else n_pass++;
      if (q.size() != 0) begin
        n_checks++;
        if ({sel, f} !== q[0]) $display("FAIL rand_word[%0d]: got %b expected %b", i, {sel, f}, q[0]);
        else n_pass++;
      end
      if (g == 1 || !req_a) begin
        req_a = (g == 1) ? (($urandom % 4) != 0) : (($urandom % 2) != 0);
        a = WIDTH'($urandom);
      end
      if (g == 2 || !req_b) begin
        req_b = (g == 2) ? (($urandom % 4) != 0) : (($urandom % 2) != 0);
        b = WIDTH'($urandom);
      end
    end
    req_a = 1'b0; req_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_release_tiebreak();
    test_reset_midburst();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
